// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter and its picker.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Burst counter must hold 0..max_burst; never narrower than one bit.
  function automatic int cnt_width(input int max_burst);
    int w;
    w = $clog2(max_burst + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority selector: picks the first set request at or
// after ptr, wrapping around, and returns it as one-hot plus binary index.
module rr_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;
  int               pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX serializer among NUM_REQ
// requesters; a grant lasts until a byte marked last or MAX_BURST bytes transfer.
//
// state | meaning
// IDLE  | no owner; next owner picked from rr_ptr when any request is valid
// BUSY  | grant_o owner streams bytes straight through to the serializer
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        tx_valid_o,
  output logic [DATA_W-1:0]           tx_data_o,
  input  logic                        tx_ready_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam bit BURST_EN = (MAX_BURST > 0);
  localparam logic [CNT_W-1:0] BURST_LAST = BURST_EN ? CNT_W'(MAX_BURST - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner_idx;
  logic [CNT_W-1:0] burst_cnt;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_valid;
  logic               owner_last;
  logic [DATA_W-1:0]  owner_data;
  logic               xfer;
  logic               burst_hit;
  logic [IDX_W-1:0]   next_ptr;

  rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // grant_o is all-zero outside BUSY, so masking by it also gates the IDLE outputs.
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_o[k]) owner_data = owner_data | req_data_i[k*DATA_W +: DATA_W];
    end
  end

  assign owner_valid = |(req_valid_i & grant_o);
  assign owner_last  = |(req_last_i & grant_o);

  assign tx_valid_o  = owner_valid;
  assign tx_data_o   = owner_valid ? owner_data : '0;
  assign req_ready_o = tx_ready_i ? grant_o : '0;

  assign xfer      = owner_valid & tx_ready_i;
  assign burst_hit = BURST_EN && (burst_cnt == BURST_LAST);
  assign next_ptr  = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      owner_idx <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid_i) begin
            state     <= BUSY;
            grant_o   <= pick_gnt;
            busy_o    <= 1'b1;
            owner_idx <= pick_idx;
            burst_cnt <= '0;
          end
        end
        BUSY: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
            // last and burst limit in the same byte still give a single release
            if (owner_last || burst_hit) begin
              state   <= IDLE;
              grant_o <= '0;
              busy_o  <= 1'b0;
              rr_ptr  <= next_ptr;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic,
// compared every cycle against an owner/pointer reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 16;
  localparam int DEPTH     = 4096;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      tx_valid_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic                      tx_ready_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      busy_o;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0]         src_mem [NUM_REQ][DEPTH];
  int                 wr_ptr  [NUM_REQ];
  int                 rd_ptr  [NUM_REQ];
  logic [NUM_REQ-1:0] en;
  logic [7:0]         obs_q [$];
  logic [7:0]         exp_q [$];
  logic [NUM_REQ-1:0] g_log [$];
  int                 pushed;

  int m_owner;
  int m_ptr;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src_mem[k][wr_ptr[k]] = {l, d};
    wr_ptr[k]++;
    pushed++;
  endtask

  function automatic bit pending();
    for (int k = 0; k < NUM_REQ; k++) if (rd_ptr[k] != wr_ptr[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush();
    for (int k = 0; k < NUM_REQ; k++) rd_ptr[k] = wr_ptr[k];
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rd_ptr[k] != wr_ptr[k] && en[k]) begin
        e = src_mem[k][rd_ptr[k]];
        req_valid_i[k] = 1'b1;
        req_last_i[k]  = e[8];
        req_data_i[k*DATA_W +: DATA_W] = e[7:0];
      end else begin
        req_valid_i[k] = 1'b0;
        req_last_i[k]  = 1'($urandom_range(0, 1));
        req_data_i[k*DATA_W +: DATA_W] = 8'($urandom);
      end
    end
  endtask

  // One clock: drive, compare against the model, record, advance the model.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_g, exp_rdy;
    logic               exp_v;
    logic [DATA_W-1:0]  exp_d;
    int                 r;
    drive();
    #2;
    exp_g = (m_owner < 0) ? '0 : (NUM_REQ'(1) << m_owner);
    exp_v = 1'b0;
    if (m_owner >= 0) exp_v = req_valid_i[m_owner];
    exp_d = exp_v ? req_data_i[m_owner*DATA_W +: DATA_W] : '0;
    exp_rdy = (m_owner >= 0 && tx_ready_i) ? exp_g : '0;
    chk("grant", 32'(grant_o), 32'(exp_g));
    chk("busy", 32'(busy_o), 32'(m_owner >= 0));
    chk("tx_valid", 32'(tx_valid_o), 32'(exp_v));
    chk("tx_data", 32'(tx_data_o), 32'(exp_d));
    chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    g_log.push_back(grant_o);
    if (!rst_i) begin
      if (tx_valid_o && tx_ready_i) obs_q.push_back(tx_data_o);
      for (int k = 0; k < NUM_REQ; k++)
        if (req_valid_i[k] && req_ready_o[k]) rd_ptr[k]++;
    end
    if (rst_i) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r = (m_ptr + i) % NUM_REQ;
        if (m_owner < 0 && req_valid_i[r]) begin
          m_owner = r; m_cnt = 0;
        end
      end
    end else if (req_valid_i[m_owner] && tx_ready_i) begin
      m_cnt++;
      if (req_last_i[m_owner] || (MAX_BURST != 0 && m_cnt == MAX_BURST)) begin
        m_ptr = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    flush();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    obs_q.delete();
    g_log.delete();
    exp_q.delete();
    en = '1;
    tx_ready_i = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    en = '1;
    tx_ready_i = 1'b1;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(pending()), 32'(0));
    repeat (2) cycle();
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [NUM_REQ-1:0] b_exp [10];
    int len;

    rst_i = 1'b1; tx_ready_i = 1'b1; en = '1;
    req_valid_i = '0; req_last_i = '0; req_data_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin wr_ptr[k] = 0; rd_ptr[k] = 0; end
    pushed = 0;
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_grant", 32'(grant_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_tx_valid", 32'(tx_valid_o), 32'(0));
    chk("rst_tx_data", 32'(tx_data_o), 32'(0));
    chk("rst_req_ready", 32'(req_ready_o), 32'(0));
    @(posedge clk_i);
    #1;

    // Requester 2 alone: 3-byte packet, then pointer sits at 3.
    do_reset();
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    cycle();
    chk("A_grant", 32'(grant_o), 32'h4);
    repeat (3) cycle();
    chk("A_release", 32'(grant_o), 32'h0);
    exp_q = '{8'h41, 8'h42, 8'h43};
    chk_stream("A");
    for (int k = 0; k < NUM_REQ; k++) push(k, 8'h50 + 8'(k), 1'b1);
    cycle();
    chk("A_ptr3", 32'(grant_o), 32'h8);
    drain(200);

    // All requesters valid, single-byte packets: 0,1,2,3,0 with idle gaps.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NUM_REQ; k++) push(k, 8'h10 + 8'(k), 1'b1);
    repeat (10) cycle();
    b_exp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    for (int i = 0; i < 10; i++) chk("B_grant_seq", 32'(g_log[i]), 32'(b_exp[i]));
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    chk_stream("B");
    drain(200);

    // Burst limit: requester 1 streams 20 bytes, 2 and 3 are served in between.
    do_reset();
    for (int i = 0; i < 20; i++) push(1, 8'h60 + 8'(i), 1'b0);
    push(2, 8'h22, 1'b1);
    push(3, 8'h33, 1'b1);
    repeat (17) cycle();
    chk("C_burst_release", 32'(grant_o), 32'h0);
    chk("C_burst_count", 32'(obs_q.size()), 32'd16);
    drain(200);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h60 + 8'(i));
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'h60 + 8'(i));
    chk_stream("C");
    chk("C_held_no_last", 32'(grant_o), 32'h2);

    // Owner 0 drops valid mid-packet while requester 3 waits.
    do_reset();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
    push(3, 8'h3D, 1'b1);
    repeat (2) cycle();
    en[0] = 1'b0;
    repeat (5) cycle();
    chk("D_hold", 32'(grant_o), 32'h1);
    chk("D_stall", 32'(obs_q.size()), 32'd1);
    drain(200);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'h3D};
    chk_stream("D");

    // Serializer back-pressure 1,0,0,1 across a 2-byte packet.
    do_reset();
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b1);
    cycle();
    tx_ready_i = 1'b1; cycle();
    tx_ready_i = 1'b0; cycle();
    tx_ready_i = 1'b0; cycle();
    tx_ready_i = 1'b1; cycle();
    chk("E_release", 32'(grant_o), 32'h0);
    exp_q = '{8'hB0, 8'hB1};
    chk_stream("E");

    // Reset in the middle of requester 2's packet.
    do_reset();
    for (int i = 0; i < 4; i++) push(2, 8'hC0 + 8'(i), 1'(i == 3));
    repeat (3) cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    flush();
    chk("F_rst_grant", 32'(grant_o), 32'h0);
    chk("F_rst_busy", 32'(busy_o), 32'h0);
    for (int k = 0; k < NUM_REQ; k++) push(k, 8'hF0 + 8'(k), 1'b1);
    cycle();
    chk("F_regrant0", 32'(grant_o), 32'h1);
    drain(200);

    // Random traffic against the model.
    do_reset();
    pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (wr_ptr[k] - rd_ptr[k] < 4 && wr_ptr[k] < DEPTH - 32 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 20);
          for (int b = 0; b < len; b++) push(k, 8'($urandom), 1'(b == len - 1));
        end
        en[k] = ($urandom_range(0, 99) < 85);
      end
      tx_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(3000);
    chk("R_total_bytes", 32'(obs_q.size()), 32'(pushed));
    chk("R_idle_end", 32'(grant_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
